led_pattern_gen: RTL and testbench

LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

---
 rtl/led_pattern_gen.sv | 194 +++++++++++++++++++
 tb/tb_led_pattern_gen.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// LED pattern generator: two debounced active-low keys select one of four
// display patterns (binary count, chase, blink, PWM breathe) and pause or
// resume the pattern advance. All outputs come from registered state.
module led_pattern_gen #(
  parameter int N_LED     = 4,
  parameter int N_KEY     = 2,
  parameter int TICK_DIV  = 25_000_000,
  parameter int DB_CYCLES = 1_000_000,
  parameter int PWM_BITS  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_KEY-1:0] key,
  output logic [N_LED-1:0] led,
  output logic [1:0]       mode,
  output logic             paused,
  output logic             tick
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int DB_W   = $clog2(DB_CYCLES);

  localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [DB_W-1:0]     DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;

  typedef enum logic [1:0] {
    MODE_COUNT   = 2'd0,
    MODE_CHASE   = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  // Pattern loaded whenever a mode is entered.
  function automatic logic [N_LED-1:0] init_pattern(input mode_e m);
    case (m)
      MODE_CHASE:   return N_LED'(1);
      MODE_BREATHE: return '0;
      default:      return '1;
    endcase
  endfunction

  // Mode sequence COUNT -> CHASE -> BLINK -> BREATHE -> COUNT.
  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_COUNT: return MODE_CHASE;
      MODE_CHASE: return MODE_BLINK;
      MODE_BLINK: return MODE_BREATHE;
      default:    return MODE_COUNT;
    endcase
  endfunction

  // ---------------------------------------------------------------------
  // Key conditioning: 2-flop synchronizer, debounce counter, press strobe
  // ---------------------------------------------------------------------
  logic [N_KEY-1:0] press;

  for (genvar k = 0; k < N_KEY; k++) begin : g_key
    logic            sync1_q, sync2_q, stable_q;
    logic [DB_W-1:0] db_cnt_q;

    // Synchronize the raw key and accept a new level once it has persisted.
    // NOTE: every clocked register uses non-blocking assignments so all flops
    // sample pre-edge values; blocking here would collapse the sync chain.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q  <= 1'b1;
        sync2_q  <= 1'b1;
        stable_q <= 1'b1;
        db_cnt_q <= '0;
      end else begin
        sync1_q <= key[k];
        sync2_q <= sync1_q;
        if (sync2_q == stable_q) begin
          db_cnt_q <= '0;
        end else if (db_cnt_q == DB_LAST) begin
          stable_q <= sync2_q;
          db_cnt_q <= '0;
        end else begin
          db_cnt_q <= db_cnt_q + 1'b1;
        end
      end
    end

    // Press strobe is high in the cycle the stable level is about to fall.
    assign press[k] = (sync2_q != stable_q) && (db_cnt_q == DB_LAST) && !sync2_q;
  end

  // ---------------------------------------------------------------------
  // Pattern control state
  // ---------------------------------------------------------------------
  mode_e               mode_q,     mode_d;
  logic                paused_q,   paused_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [N_LED-1:0]    pat_q,      pat_d;
  logic [PWM_BITS-1:0] pwm_cnt_q,  pwm_cnt_d;
  logic [PWM_BITS-1:0] duty_q,     duty_d;
  logic                dir_up_q,   dir_up_d;
  logic [N_LED-1:0]    led_q,      led_d;
  logic                tick_wrap;
  logic                pwm_wrap;

  assign tick_wrap = (tick_cnt_q == TICK_LAST);
  assign pwm_wrap  = (pwm_cnt_q == DUTY_MAX);

  // State register for mode, pause, counters, pattern and the LED pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= MODE_COUNT;
      paused_q   <= 1'b0;
      tick_cnt_q <= '0;
      pat_q      <= '1;
      pwm_cnt_q  <= '0;
      duty_q     <= '0;
      dir_up_q   <= 1'b1;
      led_q      <= '1;
    end else begin
      mode_q     <= mode_d;
      paused_q   <= paused_d;
      tick_cnt_q <= tick_cnt_d;
      pat_q      <= pat_d;
      pwm_cnt_q  <= pwm_cnt_d;
      duty_q     <= duty_d;
      dir_up_q   <= dir_up_d;
      led_q      <= led_d;
    end
  end

  // Next-state: tick/pattern advance, breathe ramp, then key actions on top.
  always_comb begin
    // NOTE: every signal gets a hold value first so no path can leave it
    // unassigned and infer a latch.
    mode_d     = mode_q;
    paused_d   = paused_q;
    tick_cnt_d = tick_cnt_q;
    pat_d      = pat_q;
    duty_d     = duty_q;
    dir_up_d   = dir_up_q;
    pwm_cnt_d  = pwm_cnt_q + 1'b1;
    led_d      = (mode_q == MODE_BREATHE) ? {N_LED{pwm_cnt_q < duty_q}} : pat_q;

    if (!paused_q) begin
      tick_cnt_d = tick_wrap ? '0 : tick_cnt_q + 1'b1;

      if (tick_wrap) begin
        case (mode_q)
          MODE_COUNT: pat_d = pat_q + 1'b1;
          MODE_CHASE: pat_d = {pat_q[N_LED-2:0], pat_q[N_LED-1]};
          MODE_BLINK: pat_d = ~pat_q;
          default:    pat_d = pat_q;
        endcase
      end

      // Triangle ramp: one duty step per PWM period, turning at both ends.
      if (mode_q == MODE_BREATHE && pwm_wrap) begin
        if (dir_up_q) begin
          if (duty_q == DUTY_MAX) begin
            dir_up_d = 1'b0;
            duty_d   = duty_q - 1'b1;
          end else begin
            duty_d   = duty_q + 1'b1;
          end
        end else begin
          if (duty_q == '0) begin
            dir_up_d = 1'b1;
            duty_d   = duty_q + 1'b1;
          end else begin
            duty_d   = duty_q - 1'b1;
          end
        end
      end
    end

    if (press[1]) begin
      paused_d = ~paused_q;
    end

    // A mode change restarts the tick period and the new mode's pattern;
    // the pause state is left untouched.
    if (press[0]) begin
      mode_d     = next_mode(mode_q);
      tick_cnt_d = '0;
      pat_d      = init_pattern(next_mode(mode_q));
      duty_d     = '0;
      dir_up_d   = 1'b1;
    end
  end

  assign led    = led_q;
  assign mode   = mode_q;
  assign paused = paused_q;
  assign tick   = tick_wrap && !paused_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen with small parameters
// (4 LEDs, 4-cycle tick, 3-cycle debounce, 3-bit PWM).
module tb_led_pattern_gen;

  logic       clk;
  logic       rst_n;
  logic [1:0] key;
  logic [3:0] led;
  logic [1:0] mode;
  logic       paused;
  logic       tick;

  led_pattern_gen #(
    .N_LED    (4),
    .N_KEY    (2),
    .TICK_DIV (4),
    .DB_CYCLES(3),
    .PWM_BITS (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .key   (key),
    .led   (led),
    .mode  (mode),
    .paused(paused),
    .tick  (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboards: expected LED values on each change, breathe high-run
  // lengths and rise-to-rise spacings.
  logic [3:0] exp_led_q[$];
  int         run_q[$];
  int         gap_q[$];

  bit         mon_en = 1'b0;
  bit         br_en  = 1'b0;
  logic [3:0] led_prev;
  int         tick_seen = 0;

  // LED-change monitor: every change pops the next expected pattern.
  always @(negedge clk) begin
    if (mon_en && led !== led_prev) begin
      if (exp_led_q.size() > 0) check("led_seq", 32'(led), 32'(exp_led_q.pop_front()));
      else                      check("led_unexpected", 32'(led), 32'(led_prev));
    end
    led_prev <= led;
  end

  // Tick monitor: a tick must never appear while paused.
  always @(negedge clk) begin
    if (tick) begin
      tick_seen++;
      check("tick_while_paused", 32'(paused), 32'h0);
    end
  end

  // Breathe monitor: measures high-run length and rise-to-rise spacing.
  int   cyc       = 0;
  int   last_rise = 0;
  bit   have_rise = 1'b0;
  logic br_prev   = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    br_prev <= led[0];
    if (!br_en) begin
      have_rise <= 1'b0;
    end else if (led[0] && !br_prev) begin
      if (have_rise) begin
        if (gap_q.size() > 0) check("breathe_period", 32'(cyc - last_rise), 32'(gap_q.pop_front()));
        else                  check("breathe_extra_rise", 32'(cyc - last_rise), 32'h0);
      end
      have_rise <= 1'b1;
      last_rise <= cyc;
    end else if (!led[0] && br_prev) begin
      check("breathe_uniform", 32'(led), 32'h0);
      if (run_q.size() > 0) check("breathe_high", 32'(cyc - last_rise), 32'(run_q.pop_front()));
      else                  check("breathe_extra_run", 32'(cyc - last_rise), 32'h0);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Drive a key level for n edges, release, then let the release debounce.
  task automatic hold_keys(input logic [1:0] lvl, input int n);
    key = lvl;
    step(n);
    key = 2'b11;
    step(8);
  endtask

  task automatic wait_led_drained(input string tag, input int budget);
    for (int i = 0; i < budget && exp_led_q.size() > 0; i++) step(1);
    check(tag, 32'(exp_led_q.size()), 32'h0);
  endtask

  task automatic wait_mode(input logic [1:0] m, input int budget);
    for (int i = 0; i < budget && mode !== m; i++) step(1);
    check("mode_reached", 32'(mode), 32'(m));
  endtask

  task automatic wait_tick(input int budget, output int waited);
    waited = 0;
    do begin
      step(1);
      waited++;
    end while (tick !== 1'b1 && waited < budget);
    check("tick_seen", 32'(tick), 32'h1);
  endtask

  initial begin
    int n;
    int hi;
    int t0;

    key   = 2'b11;
    rst_n = 1'b0;
    step(2);

    // Reset values.
    check("rst_led", 32'(led), 32'hF);
    check("rst_mode", 32'(mode), 32'h0);
    check("rst_paused", 32'(paused), 32'h0);
    check("rst_tick", 32'(tick), 32'h0);

    // COUNT from all ones: wraps to 0 then counts.
    exp_led_q.push_back(4'b0000);
    exp_led_q.push_back(4'b0001);
    exp_led_q.push_back(4'b0010);
    mon_en = 1'b1;
    rst_n  = 1'b1;
    wait_led_drained("count_seq", 40);

    // Pause press while led=0010; pattern reaches 0011 before the pause lands.
    exp_led_q.push_back(4'b0011);
    hold_keys(2'b01, 6);
    check("pause_on", 32'(paused), 32'h1);
    wait_led_drained("count_to_0011", 10);
    n = tick_seen;
    step(16);
    check("paused_no_tick", 32'(tick_seen - n), 32'h0);
    check("paused_led_hold", 32'(led), 32'h3);

    // Two-cycle glitch on the mode key is rejected.
    hold_keys(2'b10, 2);
    step(10);
    check("glitch_mode", 32'(mode), 32'h0);
    check("glitch_led", 32'(led), 32'h3);

    // Mode change while paused: CHASE initial pattern, still paused.
    exp_led_q.push_back(4'b0001);
    hold_keys(2'b10, 10);
    check("chase_mode", 32'(mode), 32'h1);
    check("chase_still_paused", 32'(paused), 32'h1);
    wait_led_drained("chase_init", 20);
    step(12);
    check("chase_paused_led", 32'(led), 32'h1);

    // Resume: chase rotates left and wraps MSB to bit 0.
    exp_led_q.push_back(4'b0010);
    exp_led_q.push_back(4'b0100);
    exp_led_q.push_back(4'b1000);
    exp_led_q.push_back(4'b0001);
    hold_keys(2'b01, 6);
    check("resume", 32'(paused), 32'h0);
    wait_led_drained("chase_seq", 80);
    mon_en = 1'b0;

    // Tick spacing.
    wait_tick(10, n);
    wait_tick(10, n);
    check("tick_interval_a", 32'(n), 32'h4);
    wait_tick(10, n);
    check("tick_interval_b", 32'(n), 32'h4);

    // BLINK: all ones on entry, inverted every tick.
    key = 2'b10;
    wait_mode(2'd2, 12);
    step(1);
    key = 2'b11;
    check("blink_init", 32'(led), 32'hF);
    wait_tick(10, n);
    step(2);
    check("blink_inv_a", 32'(led), 32'h0);
    wait_tick(10, n);
    step(2);
    check("blink_inv_b", 32'(led), 32'hF);
    step(8);

    // Both keys together: BREATHE and paused on the same edge.
    key = 2'b00;
    wait_mode(2'd3, 12);
    check("both_paused", 32'(paused), 32'h1);
    key = 2'b11;
    step(10);
    hi = 0;
    n  = tick_seen;
    for (int i = 0; i < 24; i++) begin
      step(1);
      if (led !== 4'b0000) hi++;
    end
    check("breathe_frozen_high", 32'(hi), 32'h0);
    check("breathe_frozen_tick", 32'(tick_seen - n), 32'h0);

    // Resume breathe: duty 1..7..1, a zero period, then 1,2,3.
    for (int d = 1; d <= 7; d++) run_q.push_back(d);
    for (int d = 6; d >= 1; d--) run_q.push_back(d);
    for (int d = 1; d <= 3; d++) run_q.push_back(d);
    for (int i = 0; i < 12; i++) gap_q.push_back(8);
    gap_q.push_back(16);
    gap_q.push_back(8);
    gap_q.push_back(8);
    t0    = tick_seen;
    br_en = 1'b1;
    hold_keys(2'b01, 6);
    for (int i = 0; i < 400 && run_q.size() > 0; i++) step(1);
    br_en = 1'b0;
    check("breathe_runs_done", 32'(run_q.size()), 32'h0);
    check("breathe_gaps_done", 32'(gap_q.size()), 32'h0);
    check("breathe_tick_runs", 32'(tick_seen > t0), 32'h1);

    // Reset mid-ramp and mid-debounce.
    key = 2'b10;
    step(3);
    rst_n = 1'b0;
    #1;
    check("rst2_led", 32'(led), 32'hF);
    check("rst2_mode", 32'(mode), 32'h0);
    check("rst2_paused", 32'(paused), 32'h0);
    check("rst2_tick", 32'(tick), 32'h0);
    step(1);
    rst_n = 1'b1;
    step(2);
    key = 2'b11;
    step(2);
    check("rst2_led_hold", 32'(led), 32'hF);
    step(1);
    check("rst2_led_wrap", 32'(led), 32'h0);
    step(12);
    check("rst2_no_press", 32'(mode), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100_000;
    $display("FAIL watchdog: time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
